// File: rtl/rgb2gray_pkg.sv
// Shared constants and types for the RGB-to-gray stream converter.
// Weight triplets are 8-bit fractions; each set sums to 256.
package rgb2gray_pkg;

    localparam int FRAC_BITS   = 8;
    localparam int ROUND_CONST = 128;

    typedef enum logic [1:0] {
        MODE_BT601 = 2'b00,
        MODE_BT709 = 2'b01,
        MODE_AVG   = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } weights_t;

    typedef struct packed {
        logic valid;
        logic sof;
        logic eof;
    } tag_t;

    localparam weights_t W_BT601 = '{r: 8'd77, g: 8'd150, b: 8'd29};
    localparam weights_t W_BT709 = '{r: 8'd54, g: 8'd183, b: 8'd19};
    localparam weights_t W_AVG   = '{r: 8'd85, g: 8'd85,  b: 8'd86};

    // The reserved encoding falls back to BT.601.
    function automatic weights_t weights_for(input mode_e m);
        weights_t w;
        case (m)
            MODE_BT709: w = W_BT709;
            MODE_AVG:   w = W_AVG;
            default:    w = W_BT601;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/gray_stats.sv
// Per-frame running min/max of the gray output stream.
// Results publish on the eof handshake with a one-cycle valid pulse.
module gray_stats
    import rgb2gray_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fire,
    input  logic [DATA_W-1:0] gray,
    input  logic              eof,
    output logic [DATA_W-1:0] gray_min_o,
    output logic [DATA_W-1:0] gray_max_o,
    output logic              stats_valid_o
);

    logic [DATA_W-1:0] run_min;
    logic [DATA_W-1:0] run_max;
    logic [DATA_W-1:0] next_min;
    logic [DATA_W-1:0] next_max;

    assign next_min = (gray < run_min) ? gray : run_min;
    assign next_max = (gray > run_max) ? gray : run_max;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_min       <= '1;
            run_max       <= '0;
            gray_min_o    <= '0;
            gray_max_o    <= '0;
            stats_valid_o <= 1'b0;
        end else begin
            stats_valid_o <= 1'b0;
            if (fire) begin
                if (eof) begin
                    gray_min_o    <= next_min;
                    gray_max_o    <= next_max;
                    stats_valid_o <= 1'b1;
                    run_min       <= '1;
                    run_max       <= '0;
                end else begin
                    run_min <= next_min;
                    run_max <= next_max;
                end
            end
        end
    end

endmodule

// File: rtl/rgb2gray_stream.sv
// 3-stage RGB-to-luma stream with per-frame mode latch and sof/eof tags.
// Define GRAY_STATS_EN to add per-frame min/max statistics outputs.
module rgb2gray_stream
    import rgb2gray_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int FRAME_PIXELS = 4096,
    parameter int CNT_W        = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] red_i,
    input  logic [DATA_W-1:0] green_i,
    input  logic [DATA_W-1:0] blue_i,
    input  logic              done_i,
    output logic              in_ready_o,
    input  logic [1:0]        mode_i,
    output logic [DATA_W-1:0] grayscale_o,
    output logic              done_o,
    input  logic              out_ready_i,
    output logic              sof_o,
    output logic              eof_o,
    output logic [CNT_W-1:0]  pix_cnt_o
`ifdef GRAY_STATS_EN
    ,
    output logic [DATA_W-1:0] gray_min_o,
    output logic [DATA_W-1:0] gray_max_o,
    output logic              stats_valid_o
`endif
);

    localparam int PW = DATA_W + 8;
    localparam int SW = DATA_W + 10;

    logic     adv;
    logic     accept;
    logic     first;
    logic     last;
    mode_e    mode_q;
    mode_e    mode_eff;
    weights_t w;

    assign adv        = !done_o | out_ready_i;
    assign in_ready_o = adv;
    assign accept     = done_i & adv;
    assign first      = (pix_cnt_o == '0);
    assign last       = (pix_cnt_o == CNT_W'(FRAME_PIXELS - 1));

    // The frame's first pixel uses mode_i directly; it is latched that edge.
    assign mode_eff = first ? mode_e'(mode_i) : mode_q;
    assign w        = weights_for(mode_eff);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_cnt_o <= '0;
            mode_q    <= MODE_BT601;
        end else if (accept) begin
            pix_cnt_o <= last ? '0 : pix_cnt_o + CNT_W'(1);
            if (first) begin
                mode_q <= mode_e'(mode_i);
            end
        end
    end

    tag_t          t1;
    logic [PW-1:0] p_r;
    logic [PW-1:0] p_g;
    logic [PW-1:0] p_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t1  <= '0;
            p_r <= '0;
            p_g <= '0;
            p_b <= '0;
        end else if (adv) begin
            t1.valid <= done_i;
            t1.sof   <= done_i & first;
            t1.eof   <= done_i & last;
            p_r      <= PW'(red_i) * PW'(w.r);
            p_g      <= PW'(green_i) * PW'(w.g);
            p_b      <= PW'(blue_i) * PW'(w.b);
        end
    end

    tag_t          t2;
    logic [SW-1:0] sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t2  <= '0;
            sum <= '0;
        end else if (adv) begin
            t2  <= t1;
            sum <= SW'(p_r) + SW'(p_g) + SW'(p_b)
                 + SW'(ROUND_CONST);
        end
    end

    logic [SW-1:0]     shifted;
    logic [DATA_W-1:0] clamped;

    assign shifted = sum >> FRAC_BITS;

    always_comb begin
        clamped = shifted[DATA_W-1:0];
        if (|shifted[SW-1:DATA_W]) begin
            clamped = '1;
        end
    end

    // Data only reloads on a real pixel so bubbles never disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_o      <= 1'b0;
            sof_o       <= 1'b0;
            eof_o       <= 1'b0;
            grayscale_o <= '0;
        end else if (adv) begin
            done_o <= t2.valid;
            sof_o  <= t2.sof;
            eof_o  <= t2.eof;
            if (t2.valid) begin
                grayscale_o <= clamped;
            end
        end
    end

`ifdef GRAY_STATS_EN
    gray_stats #(
        .DATA_W (DATA_W)
    ) u_stats (
        .clk           (clk),
        .rst           (rst),
        .fire          (done_o & out_ready_i),
        .gray          (grayscale_o),
        .eof           (eof_o),
        .gray_min_o    (gray_min_o),
        .gray_max_o    (gray_max_o),
        .stats_valid_o (stats_valid_o)
    );
`endif

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Self-checking bench for rgb2gray_stream (DATA_W=8, FRAME_PIXELS=4).
// Table vectors plus scoreboard-driven stall, mode-latch and reset sequences.
module tb_rgb2gray_stream;

    localparam int DW = 8;
    localparam int FP = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] red_i = '0;
    logic [DW-1:0] green_i = '0;
    logic [DW-1:0] blue_i = '0;
    logic          done_i = 1'b0;
    logic          in_ready_o;
    logic [1:0]    mode_i = 2'b00;
    logic [DW-1:0] grayscale_o;
    logic          done_o;
    logic          out_ready_i = 1'b1;
    logic          sof_o;
    logic          eof_o;
    logic [CW-1:0] pix_cnt_o;
`ifdef GRAY_STATS_EN
    logic [DW-1:0] gray_min_o;
    logic [DW-1:0] gray_max_o;
    logic          stats_valid_o;
    int            stat_pulses = 0;
`endif

    rgb2gray_stream #(
        .DATA_W       (DW),
        .FRAME_PIXELS (FP),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .red_i       (red_i),
        .green_i     (green_i),
        .blue_i      (blue_i),
        .done_i      (done_i),
        .in_ready_o  (in_ready_o),
        .mode_i      (mode_i),
        .grayscale_o (grayscale_o),
        .done_o      (done_o),
        .out_ready_i (out_ready_i),
        .sof_o       (sof_o),
        .eof_o       (eof_o),
`ifdef GRAY_STATS_EN
        .gray_min_o    (gray_min_o),
        .gray_max_o    (gray_max_o),
        .stats_valid_o (stats_valid_o),
`endif
        .pix_cnt_o   (pix_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gray;
        logic       sof;
        logic       eof;
    } exp_t;

    typedef struct {
        int         r;
        int         g;
        int         b;
        logic [1:0] m;
        int         exp;
    } vec_t;

    exp_t       q[$];
    vec_t       tab[12];
    int         checks = 0;
    int         errors = 0;
    int         outs = 0;
    int         m_cnt = 0;
    logic [1:0] m_mode = 2'b00;

    function automatic logic [7:0] ref_gray(input int r, input int g,
                                            input int b, input logic [1:0] m);
        int wr, wg, wb, s;
        case (m)
            2'b01:   begin wr = 54; wg = 183; wb = 19; end
            2'b10:   begin wr = 85; wg = 85;  wb = 86; end
            default: begin wr = 77; wg = 150; wb = 29; end
        endcase
        s = (r * wr + g * wg + b * wb + 128) >> 8;
        if (s > 255) s = 255;
        return s[7:0];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && done_o && out_ready_i) begin
            checks++;
            outs++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL out%0d: unexpected output gray=%0d",
                         outs, grayscale_o);
            end else begin
                e = q.pop_front();
                if (grayscale_o !== e.gray || sof_o !== e.sof
                    || eof_o !== e.eof) begin
                    errors++;
                    $display("FAIL out%0d: gray=%0d sof=%b eof=%b, expected gray=%0d sof=%b eof=%b",
                             outs, grayscale_o, sof_o, eof_o,
                             e.gray, e.sof, e.eof);
                end
            end
        end
`ifdef GRAY_STATS_EN
        if (rst && stats_valid_o) stat_pulses++;
`endif
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input int g, input int b,
                        input logic [1:0] m, input bit use_tab,
                        input int tab_exp);
        exp_t e;
        int   n;
        red_i   = r[7:0];
        green_i = g[7:0];
        blue_i  = b[7:0];
        mode_i  = m;
        done_i  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready_o && n < 100);
        if (!in_ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready_o=0 after %0d cycles", n);
            done_i = 1'b0;
            return;
        end
        e.gray = use_tab ? tab_exp[7:0]
                         : ref_gray(r, g, b, (m_cnt == 0) ? m : m_mode);
        if (m_cnt == 0) m_mode = m;
        e.sof = (m_cnt == 0);
        e.eof = (m_cnt == FP - 1);
        q.push_back(e);
        m_cnt = (m_cnt + 1) % FP;
        @(posedge clk);
        #1;
        check("pix_cnt", pix_cnt_o, m_cnt);
        done_i = 1'b0;
    endtask

    task automatic filler(input int n);
        for (int i = 0; i < n; i++) begin
            send($urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), 2'($urandom_range(0, 3)), 0, 0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", q.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0]  = '{255, 0, 0, 2'b00, 77};
        tab[1]  = '{0, 255, 0, 2'b01, 182};
        tab[2]  = '{255, 0, 0, 2'b10, 85};
        tab[3]  = '{100, 100, 100, 2'b00, 100};
        tab[4]  = '{100, 100, 100, 2'b01, 100};
        tab[5]  = '{100, 100, 100, 2'b10, 100};
        tab[6]  = '{100, 100, 100, 2'b11, 100};
        tab[7]  = '{0, 0, 255, 2'b00, 29};
        tab[8]  = '{255, 255, 255, 2'b00, 255};
        tab[9]  = '{255, 255, 255, 2'b10, 255};
        tab[10] = '{0, 0, 0, 2'b01, 0};
        tab[11] = '{0, 0, 255, 2'b01, 19};

        #2 rst = 1'b0;
        #1;
        check("rst_done", done_o, 0);
        check("rst_gray", grayscale_o, 0);
        check("rst_sof", sof_o, 0);
        check("rst_eof", eof_o, 0);
        check("rst_pix_cnt", pix_cnt_o, 0);
        check("rst_in_ready", in_ready_o, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sync();

        send(255, 0, 0, 2'b00, 1, 77);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("latency_c%0d", k), done_o, (k == 3) ? 1 : 0);
        end
        sync();
        filler(3);

        for (int i = 0; i < 12; i++) begin
            send(tab[i].r, tab[i].g, tab[i].b, tab[i].m, 1, tab[i].exp);
            filler(3);
        end

        for (int i = 0; i < 8; i++) filler(1);

        fork
            for (int i = 0; i < 8; i++) filler(1);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready_i = 1'b0;
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("stall_done", done_o, 1);
                check("stall_in_ready", in_ready_o, 0);
                @(posedge clk);
                #1 out_ready_i = 1'b1;
            end
        join
        drain();
        sync();

        send(0, 255, 0, 2'b00, 1, 149);
        send(0, 255, 0, 2'b00, 1, 149);
        send(0, 255, 0, 2'b01, 1, 149);
        send(0, 255, 0, 2'b01, 1, 149);
        for (int i = 0; i < 4; i++) send(0, 255, 0, 2'b01, 1, 182);
        drain();
        sync();

        out_ready_i = 1'b0;
        filler(3);
        rst = 1'b0;
        #1;
        check("midrst_done", done_o, 0);
        check("midrst_pix_cnt", pix_cnt_o, 0);
        check("midrst_sof", sof_o, 0);
        q.delete();
        m_cnt = 0;
        m_mode = 2'b00;
        sync();
        rst = 1'b1;
        out_ready_i = 1'b1;
        send(0, 255, 0, 2'b01, 1, 182);
        filler(3);
        drain();

`ifdef GRAY_STATS_EN
        sync();
        stat_pulses = 0;
        send(10, 10, 10, 2'b10, 1, 10);
        send(200, 200, 200, 2'b10, 1, 200);
        send(50, 50, 50, 2'b10, 1, 50);
        send(3, 3, 3, 2'b10, 1, 3);
        drain();
        repeat (3) @(negedge clk);
        check("stats_pulses", stat_pulses, 1);
        check("stats_min", gray_min_o, 3);
        check("stats_max", gray_max_o, 200);
`endif

        repeat (5) @(negedge clk);
        check("final_queue", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
